// File: rtl/pio_key_irq_master_pkg.sv
// Shared definitions for the PIO key interrupt master: the PIO register
// map and the controller state enumeration.
package pio_key_irq_master_pkg;

    // PIO register word addresses
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // Controller states
    typedef enum logic [2:0] {
        INIT_MASK,
        IDLE,
        RD_CAP,
        RD_WAIT,
        WR_CLR,
        SETTLE
    } state_t;

endpackage

// File: rtl/pio_key_irq_master.sv
// Avalon-MM master that services a key PIO. It programs the interrupt mask
// after reset, then on each interrupt reads the edge-capture register,
// clears the bits it saw and hands them to a consumer as one event word.
// Events arriving before the consumer takes the previous one are merged
// and flagged by a sticky overflow bit.
module pio_key_irq_master
    import pio_key_irq_master_pkg::*;
#(
    parameter int              WIDTH        = 3,
    parameter logic [WIDTH-1:0] MASK_INIT   = '1,
    parameter int              READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest,
    input  logic             irq,
    output logic             event_valid,
    output logic [WIDTH-1:0] event_data,
    input  logic             event_ready,
    output logic             overflow
);

    // Last count value of the read-latency counter, i.e. the cycle on
    // which readdata is valid.
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    state_t           state;
    logic [WIDTH-1:0] cap;
    logic [1:0]       lat_count;
    logic [WIDTH-1:0] read_keys;
    logic             unused_readdata;

    // Only the low WIDTH bits of readdata carry key state.
    assign read_keys       = avm_readdata[WIDTH-1:0];
    assign unused_readdata = ^avm_readdata;

    // Controller FSM with registered bus commands and event outputs. A command
    // is loaded into the output registers on the transition into the state
    // that owns it, so it holds unchanged while waitrequest stalls it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INIT_MASK;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            cap           <= '0;
            lat_count     <= '0;
            event_valid   <= 1'b0;
            event_data    <= '0;
            overflow      <= 1'b0;
        end else begin
            if (event_valid && event_ready) begin
                event_valid <= 1'b0;
            end

            case (state)
                INIT_MASK: begin
                    if (!avm_write) begin
                        avm_write     <= 1'b1;
                        avm_address   <= PIO_ADDR_MASK;
                        avm_writedata <= 32'(MASK_INIT);
                    end else if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        state     <= IDLE;
                    end
                end

                IDLE: begin
                    if (irq) begin
                        avm_read    <= 1'b1;
                        avm_address <= PIO_ADDR_EDGE;
                        state       <= RD_CAP;
                    end
                end

                RD_CAP: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        lat_count <= '0;
                        state     <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (lat_count == LAT_LAST) begin
                        cap <= read_keys;
                        if (read_keys != '0) begin
                            avm_write     <= 1'b1;
                            avm_address   <= PIO_ADDR_EDGE;
                            avm_writedata <= 32'(read_keys);
                            state         <= WR_CLR;
                        end else begin
                            state <= SETTLE;
                        end
                    end else begin
                        lat_count <= lat_count + 2'd1;
                    end
                end

                WR_CLR: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        state     <= SETTLE;
                        if (!event_valid || event_ready) begin
                            event_data  <= cap;
                            event_valid <= 1'b1;
                        end else begin
                            event_data <= event_data | cap;
                            overflow   <= 1'b1;
                        end
                    end
                end

                SETTLE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= INIT_MASK;
                end
            endcase
        end
    end

endmodule
